// File: rtl/cp0_unit_if.sv
// cp0_unit_if: groups the M-stage facing signals of coprocessor 0.
// master = pipeline side (drives M-stage indications, reads flush/EPC),
// slave  = cp0_unit side.
// There is no valid/ready pair on this bus. Every input is sampled at each
// rising clk edge, and oINT/oData are combinational in the same cycle.
interface cp0_unit_if;
  logic [4:0]  iA1;
  logic [31:0] oData;
  logic [4:0]  iA2;
  logic [31:0] iWD;
  logic        iWE;
  logic [31:0] iPC8;
  logic        iBD;
  logic        iEXC;
  logic [4:0]  iExcCode;
  logic [31:0] iBadVAddr;
  logic [5:0]  iHWInt;
  logic        iEXL_clr;
  logic        oINT;
  logic [31:0] oEPC;

  modport master (
    output iA1, iA2, iWD, iWE, iPC8, iBD, iEXC, iExcCode, iBadVAddr, iHWInt, iEXL_clr,
    input  oData, oINT, oEPC
  );

  modport slave (
    input  iA1, iA2, iWD, iWE, iPC8, iBD, iEXC, iExcCode, iBadVAddr, iHWInt, iEXL_clr,
    output oData, oINT, oEPC
  );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 (SR/Cause/EPC/PRId) behind the M stage.
// Arbitrates interrupt/exception entry, serves mfc0/mtc0, and drives the
// flush request oINT plus the registered return address oEPC.
// Optional feature macro: CP0_BADVADDR_EN adds read-only BadVAddr (reg 8).
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h2024_0701
) (
  input logic       clk,
  input logic       reset,
  cp0_unit_if.slave bus
);

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  excCode;
  // EPC keeps only the word-aligned part; bits [1:0] are always zero
  logic [29:0] epc;

  logic        intReq;
  logic        excReq;
  logic        take;
  logic [31:0] epcEntry;
  logic [31:0] srVal;
  logic [31:0] causeVal;
  logic [31:0] badVAddrVal;

  assign intReq   = (|(ip & im)) & ie & ~exl;
  assign excReq   = bus.iEXC & ~exl;
  assign take     = intReq | excReq;
  // A delay-slot instruction returns to its branch, one word earlier
  assign epcEntry = bus.iPC8 - (bus.iBD ? 32'd12 : 32'd8);

  assign srVal    = {16'h0000, im, 8'h00, exl, ie};
  assign causeVal = {bd, 15'h0000, ip, 3'b000, excCode, 2'b00};

  assign bus.oINT = take;
  assign bus.oEPC = {epc, 2'b00};

`ifdef CP0_BADVADDR_EN
  logic [31:0] badVAddr;

  // Capture the faulting address on address-error entries only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      badVAddr <= 32'h0;
    end else if (take && !intReq && (bus.iExcCode == 5'd4 || bus.iExcCode == 5'd5)) begin
      badVAddr <= bus.iBadVAddr;
    end
  end

  assign badVAddrVal = badVAddr;
`else
  logic unusedBadVAddr;
  assign unusedBadVAddr = ^bus.iBadVAddr;
  assign badVAddrVal    = 32'h0;
`endif

  // mfc0 read mux; no bypass from a same-cycle mtc0
  always_comb begin
    bus.oData = 32'h0;
    case (bus.iA1)
      5'd8:    bus.oData = badVAddrVal;
      5'd12:   bus.oData = srVal;
      5'd13:   bus.oData = causeVal;
      5'd14:   bus.oData = {epc, 2'b00};
      5'd15:   bus.oData = PRID;
      default: bus.oData = 32'h0;
    endcase
  end

  // CP0 state: IP sampling, entry (highest priority), else mtc0 then eret
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im      <= 6'h00;
      exl     <= 1'b0;
      ie      <= 1'b0;
      bd      <= 1'b0;
      ip      <= 6'h00;
      excCode <= 5'h00;
      epc     <= 30'h0;
    end else begin
      ip <= bus.iHWInt;
      if (take) begin
        // Entry drops any concurrent mtc0 and overrides eret
        exl     <= 1'b1;
        excCode <= intReq ? 5'd0 : bus.iExcCode;
        bd      <= bus.iBD;
        epc     <= epcEntry[31:2];
      end else begin
        if (bus.iWE) begin
          case (bus.iA2)
            5'd12: begin
              im  <= bus.iWD[15:10];
              exl <= bus.iWD[1];
              ie  <= bus.iWD[0];
            end
            5'd14:   epc <= bus.iWD[31:2];
            default: ;
          endcase
        end
        // Placed after the mtc0 write so eret wins on EXL
        if (bus.iEXL_clr) begin
          exl <= 1'b0;
        end
      end
    end
  end

endmodule
